// File: rtl/result_bcd_converter_pkg.sv
// Shared types and constants for the signed-result to BCD converter.
package result_bcd_converter_pkg;

    localparam int unsigned InW       = 16;
    localparam int unsigned NumDigits = 5;
    localparam int unsigned NumIters  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StDone
    } state_e;

    // Leading-zero blanking: units always lit, digit k lit if any digit at or above k is nonzero.
    function automatic logic [NumDigits-1:0] digit_enable(input logic [4*NumDigits-1:0] bcd);
        logic [NumDigits-1:0] en;
        en    = '0;
        en[0] = 1'b1;
        for (int k = 1; k < int'(NumDigits); k++) begin
            en[k] = |(bcd >> (4 * k));
        end
        return en;
    endfunction

endpackage

// File: rtl/result_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Pure combinational correction.
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Converts a signed divider result into sign + 5 BCD digits using one
// double-dabble iteration per cycle, with leading-zero display enables.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int unsigned IN_W       = InW,
    parameter int unsigned NUM_DIGITS = NumDigits
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         in_result,
    output logic                    busy,
    output logic                    out_valid,
    output logic                    out_sign,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_digit_en
);

    localparam int unsigned BcdW = 4 * NUM_DIGITS;
    localparam int unsigned CntW = $clog2(NumIters);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [BcdW-1:0]       bcd_q, bcd_d;
    logic [IN_W-1:0]       mag_q, mag_d;
    logic                  sign_q, sign_d;
    logic                  out_sign_q, out_sign_d;
    logic [BcdW-1:0]       out_bcd_q, out_bcd_d;
    logic [NUM_DIGITS-1:0] out_en_q, out_en_d;

    logic [BcdW-1:0]       bcd_adj;
    logic [BcdW-1:0]       bcd_shift;

    for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    // Corrected digits shifted left with the magnitude MSB entering the units digit.
    always_comb begin
        bcd_shift = BcdW'({bcd_adj, mag_q[IN_W-1]});
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        mag_d      = mag_q;
        sign_d     = sign_q;
        out_sign_d = out_sign_q;
        out_bcd_d  = out_bcd_q;
        out_en_d   = out_en_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = in_result[IN_W-1];
                    // 16'h8000 negates to itself, which read unsigned is 32768.
                    mag_d   = in_result[IN_W-1] ? (~in_result + 1'b1) : in_result;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StConvert;
                end
            end
            StConvert: begin
                bcd_d = bcd_shift;
                mag_d = {mag_q[IN_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(NumIters - 1)) begin
                    state_d    = StDone;
                    out_bcd_d  = bcd_shift;
                    out_sign_d = sign_q;
                    out_en_d   = digit_enable(bcd_shift);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bcd_q      <= '0;
            mag_q      <= '0;
            sign_q     <= 1'b0;
            out_sign_q <= 1'b0;
            out_bcd_q  <= '0;
            out_en_q   <= NUM_DIGITS'(1);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            mag_q      <= mag_d;
            sign_q     <= sign_d;
            out_sign_q <= out_sign_d;
            out_bcd_q  <= out_bcd_d;
            out_en_q   <= out_en_d;
        end
    end

    // Outputs decoded from state and held result registers.
    always_comb begin
        busy         = (state_q != StIdle);
        out_valid    = (state_q == StDone);
        out_sign     = out_sign_q;
        out_bcd      = out_bcd_q;
        out_digit_en = out_en_q;
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: scoreboard of expected results
// popped on each out_valid pulse, plus directed timing and reset scenarios.
module tb_result_bcd_converter;

    typedef struct packed {
        logic [19:0] bcd;
        logic        sign;
        logic [4:0]  en;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_result;
    logic        busy;
    logic        out_valid;
    logic        out_sign;
    logic [19:0] out_bcd;
    logic [4:0]  out_digit_en;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    result_bcd_converter #(
        .IN_W       (16),
        .NUM_DIGITS (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_sign     (out_sign),
        .out_bcd      (out_bcd),
        .out_digit_en (out_digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division of the absolute value.
    function automatic exp_t model(input logic [15:0] r);
        exp_t e;
        int   m;
        m      = r[15] ? (65536 - int'(r)) : int'(r);
        e.sign = r[15];
        e.bcd  = '0;
        for (int k = 0; k < 5; k++) begin
            e.bcd[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        e.en = 5'b00001;
        for (int k = 1; k < 5; k++) begin
            e.en[k] = ((e.bcd >> (4 * k)) != 20'd0);
        end
        return e;
    endfunction

    // Scoreboard: every out_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got pulse with bcd=%h, required no pulse",
                         out_bcd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                vectors += 3;
                if (out_bcd !== e.bcd) begin
                    miscompares++;
                    $display("FAIL out_bcd: got %h, required %h", out_bcd, e.bcd);
                end
                if (out_sign !== e.sign) begin
                    miscompares++;
                    $display("FAIL out_sign: got %b, required %b", out_sign, e.sign);
                end
                if (out_digit_en !== e.en) begin
                    miscompares++;
                    $display("FAIL out_digit_en: got %b, required %b", out_digit_en, e.en);
                end
            end
        end
    end

    task automatic drive_one(input logic [15:0] v);
        @(negedge clk);
        in_valid  = 1'b1;
        in_result = v;
        sb.push_back(model(v));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_result = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, out_valid, out_sign, out_bcd, out_digit_en} !== {3'b000, 20'h0, 5'b00001}) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b ov=%b sign=%b bcd=%h en=%b, required 0 0 0 00000 00001",
                     busy, out_valid, out_sign, out_bcd, out_digit_en);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_latency();
        int first_seen;
        first_seen = -1;
        @(negedge clk);
        in_valid  = 1'b1;
        in_result = 16'h0000;
        sb.push_back(model(16'h0000));
        @(posedge clk);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid && first_seen < 0) first_seen = k;
            if (k < 20) @(posedge clk);
        end
        vectors++;
        if (first_seen != 16) begin
            miscompares++;
            $display("FAIL latency: out_valid after %0d edges past accept, required 16", first_seen);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            sb.delete();
            $display("FAIL zero_result: no output observed, required one result");
        end
    endtask

    task automatic test_values();
        logic [15:0] vals[4];
        exp_t        prev;
        vals = '{16'sd127, 16'hFF80, 16'h8000, 16'd60001};
        prev = model(16'h0000);
        foreach (vals[i]) begin
            drive_one(vals[i]);
            repeat (5) @(negedge clk);
            vectors++;
            if (out_bcd !== prev.bcd || out_sign !== prev.sign || out_digit_en !== prev.en) begin
                miscompares++;
                $display("FAIL hold_while_busy: got bcd=%h sign=%b en=%b, required %h %b %b",
                         out_bcd, out_sign, out_digit_en, prev.bcd, prev.sign, prev.en);
            end
            prev = model(vals[i]);
            for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
            vectors++;
            if (sb.size() != 0) begin
                miscompares++;
                sb.delete();
                $display("FAIL timeout_value: no output for %h, required one result", vals[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_result = 16'd5;
        sb.push_back(model(16'd5));
        @(posedge clk);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (k == 3) in_result = 16'd9;
            if (k < 17) @(posedge clk);
        end
        vectors++;
        if (busy_cnt != 17) begin
            miscompares++;
            $display("FAIL busy_cycles: got %0d cycles, required 17", busy_cnt);
        end
        sb.push_back(model(16'd9));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reaccept_18: got busy=%b, required 1", busy);
        end
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            sb.delete();
            $display("FAIL timeout_b2b: %0d results pending, required 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_result = 16'd1000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({busy, out_valid, out_sign, out_bcd, out_digit_en} !== {3'b000, 20'h0, 5'b00001}) begin
            miscompares++;
            $display("FAIL abort_reset: got busy=%b ov=%b sign=%b bcd=%h en=%b, required 0 0 0 00000 00001",
                     busy, out_valid, out_sign, out_bcd, out_digit_en);
        end
        repeat (20) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL abort_no_pulse: got %0d pulses, required 0", pulses);
        end
        drive_one(16'd1000);
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            sb.delete();
            $display("FAIL timeout_after_abort: no output, required one result");
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_zero_latency();
        test_values();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  IN_W, 16, width of the signed divider result; only 16 is supported.
  NUM_DIGITS, 5, number of BCD output digits; only 5 is supported.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state changes on its rising edge.
  rst_n  input  1  reset, synchronous and active-low.
  in_valid  input  1  in_result holds a new divider result this cycle.
  in_result  input  16  signed two's-complement quotient from the upstream divider.
  busy  output  1  conversion in progress; in_valid is ignored while high.
  out_valid  output  1  one-cycle pulse; out_* updated with a new conversion.
  out_sign  output  1  1 = result was negative.
  out_bcd  output  20  magnitude as 5 BCD digits; [19:16] is ten-thousands, [3:0] is units.
  out_digit_en  output  5  per-digit display enable with leading-zero blanking; bit 0 is units.

Function
REQ-003 FSM SHALL have exactly three states: IDLE, CONVERT, DONE.
REQ-004 In IDLE, in_valid=1 at a rising edge SHALL capture the conversion inputs.
  - Captured sign = in_result[15].
  - Captured 16-bit unsigned magnitude = in_result[15] ? (~in_result + 1) : in_result.
  - On the same edge: 5-digit BCD accumulator cleared to 0, iteration counter cleared to 0, state -> CONVERT.
REQ-005 Magnitude of 16'h8000 SHALL be 32768 (unsigned), with no overflow or saturation.
REQ-006 Each CONVERT cycle SHALL perform one double-dabble iteration.
  - First, every BCD digit >= 5 gets +3.
  - Then {bcd, magnitude} shifts left by 1.
REQ-007 After the 16th iteration (counter == 15 at that edge), state SHALL go CONVERT -> DONE.
REQ-008 Entering DONE SHALL update out_bcd, out_sign and out_digit_en from the accumulator and captured sign.
  - out_valid = 1 for exactly the one DONE cycle.
  - Next edge: DONE -> IDLE unconditionally.
REQ-009 Latency: for in_valid accepted at edge E0, out_valid SHALL be high in the cycle after edge E0+16.
REQ-010 Minimum spacing between accepted inputs SHALL be 18 cycles.
REQ-011 busy SHALL be 1 in CONVERT and DONE and 0 in IDLE.
REQ-012 in_valid while busy=1 SHALL be ignored; no queuing; in_result changes during conversion have no effect.
REQ-013 out_digit_en[0] SHALL always be 1.
  - out_digit_en[k] (k=1..4) = 1 iff any digit at index >= k is nonzero.
REQ-014 Zero SHALL never be signed: out_sign = 0 for in_result = 0.
REQ-015 out_sign, out_bcd and out_digit_en SHALL hold their values until the next DONE, including while busy.

Reset
REQ-016 rst_n = 0 at a rising edge SHALL force:
  - state IDLE, counter 0, accumulator 0, captured operands 0;
  - busy = 0, out_valid = 0, out_sign = 0, out_bcd = 0, out_digit_en = 5'b00001.
REQ-017 Reset asserted mid-CONVERT or in DONE SHALL abort the conversion with no out_valid pulse.
  - Reset SHALL take priority over in_valid on the same edge.

Structure
REQ-018 A shared package SHALL hold the state enum type (IDLE, CONVERT, DONE), IN_W, NUM_DIGITS and the iteration-count constant 16.
REQ-019 One combinational sub-module, bcd_add3, SHALL implement the per-digit (d >= 5 ? d+3 : d) correction.
  - It SHALL be instantiated NUM_DIGITS times.
REQ-020 Register and next-state logic SHALL stay in result_bcd_converter.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
  - in_result = 0 -> out_bcd = 20'h00000, out_sign = 0, out_digit_en = 5'b00001, out_valid exactly 17 cycles after in_valid is sampled.
  - in_result = 16'sd127 -> out_bcd = 20'h00127, out_sign = 0, out_digit_en = 5'b00111.
  - in_result = -16'sd128 (16'hFF80) -> out_bcd = 20'h00128, out_sign = 1, out_digit_en = 5'b00111.
  - in_result = 16'h8000 -> out_bcd = 20'h32768, out_sign = 1, out_digit_en = 5'b11111.
  - in_valid held high with in_result 16'd5 then 16'd9 presented 3 cycles later -> only 5 converted, busy high 17 cycles, next acceptance 18 cycles after the first.
  - rst_n low for 1 cycle, 6 cycles into converting 16'd1000 -> no out_valid, all outputs at reset values, next in_valid accepted normally.
